// File: rtl/imem_uart_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory loader.
package imem_uart_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_RUN,
        ST_ERR
    } ldr_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Received-byte stream from the UART receiver to the loader FSM.
interface imem_uart_loader_if;

    logic [7:0] data;   // received byte, held until the next byte
    logic       valid;  // one-cycle pulse: data holds a good byte
    logic       ferr;   // one-cycle pulse: stop bit was low, byte dropped

    modport master (output data, valid, ferr);
    modport slave  (input  data, valid, ferr);

endinterface

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start re-check,
// centre sampling, stop-bit check with byte-valid / frame-error pulses.
module uart_rx
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_i,
    imem_uart_loader_if.master rx_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       st_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            ferr_q;

    // Synchronize the async line; prev_q gives the falling-edge reference.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Bit-timing FSM; pulses are registered so they last exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (st_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        st_q  <= RX_START;
                        cnt_q <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        // A glitch shorter than half a bit is not a start bit.
                        cnt_q <= '0;
                        bit_q <= '0;
                        st_q  <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) st_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        st_q  <= RX_IDLE;
                        if (sync2_q) begin
                            valid_q <= 1'b1;
                            data_q  <= shift_q;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_o.data  = data_q;
    assign rx_o.valid = valid_q;
    assign rx_o.ferr  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// UART program loader: receives A5 <N> <4N little-endian bytes> and fills a
// DEPTH x 32 instruction memory, holding the CPU in reset until the load ends.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic        UART_RX,
    input  logic [31:0] IMEM_RD_ADDR,
    output logic [31:0] IMEM_RD_DATA,
    output logic        CPU_RST_N,
    output logic        LOAD_DONE,
    output logic        FRAME_ERR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    imem_uart_loader_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk_i (CLK100MHZ),
        .rst_i (RST),
        .rx_i  (UART_RX),
        .rx_o  (rx_if)
    );

    ldr_state_e  state_q;
    logic [7:0]  len_q;
    logic [7:0]  wcnt_q;
    logic [1:0]  bcnt_q;
    logic [23:0] word_q;      // b2,b1,b0 of the word being assembled
    logic        last_q;      // final word written; enter RUN this cycle
    logic        cpu_rst_n_q;
    logic        load_done_q;
    logic        frame_err_q;
    logic [31:0] mem_q [DEPTH];

    logic len_ok;
    logic mem_we;

    assign len_ok = (rx_if.data != 8'd0) && (32'(rx_if.data) <= 32'(DEPTH));
    assign mem_we = rx_if.valid && !RST && !last_q &&
                    (state_q == ST_DATA) && (bcnt_q == 2'd3);

    // Loader FSM with registered CPU reset / status outputs.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wcnt_q      <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (rx_if.ferr) frame_err_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (rx_if.valid && rx_if.data == SYNC_BYTE) begin
                        state_q     <= ST_LEN;
                        wcnt_q      <= '0;
                        bcnt_q      <= '0;
                        cpu_rst_n_q <= 1'b0;
                        load_done_q <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (rx_if.valid) begin
                        if (len_ok) begin
                            state_q <= ST_DATA;
                            len_q   <= rx_if.data;
                        end else begin
                            state_q     <= ST_ERR;
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (last_q) begin
                        // Release the CPU one cycle after the last word lands.
                        last_q      <= 1'b0;
                        state_q     <= ST_RUN;
                        cpu_rst_n_q <= 1'b1;
                        load_done_q <= 1'b1;
                    end else if (rx_if.valid) begin
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            wcnt_q <= wcnt_q + 8'd1;
                            last_q <= (wcnt_q == len_q - 8'd1);
                        end else begin
                            word_q <= {rx_if.data, word_q[23:8]};
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge CLK100MHZ) begin
        if (mem_we) mem_q[wcnt_q[AW-1:0]] <= {rx_if.data, word_q};
    end

    assign IMEM_RD_DATA = (IMEM_RD_ADDR < 32'(DEPTH)) ? mem_q[IMEM_RD_ADDR[AW-1:0]]
                                                      : NOP_INSTR;
    assign CPU_RST_N    = cpu_rst_n_q;
    assign LOAD_DONE    = load_done_q;
    assign FRAME_ERR    = frame_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serializes 8N1 frames onto UART_RX and
// checks memory contents, CPU reset timing and the sticky error flag.
module tb_imem_uart_loader;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [31:0] addr = '0;
    wire  [31:0] rd_data;
    wire         cpu_rst_n, load_done, frame_err;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, rise_cyc = -1, fall_cyc = -1, chg_cyc = -1;
    logic        prev_rn = 1'b0;
    logic [31:0] prev_rd = '0;

    always #5 clk = ~clk;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .CLK100MHZ    (clk),
        .RST          (rst),
        .UART_RX      (rx),
        .IMEM_RD_ADDR (addr),
        .IMEM_RD_DATA (rd_data),
        .CPU_RST_N    (cpu_rst_n),
        .LOAD_DONE    (load_done),
        .FRAME_ERR    (frame_err)
    );

    // Edge timestamps of CPU_RST_N and of read-data changes, taken mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!prev_rn && cpu_rst_n) rise_cyc = cyc;
        if (prev_rn && !cpu_rst_n) fall_cyc = cyc;
        if (rd_data !== prev_rd)   chg_cyc  = cyc;
        prev_rn = cpu_rst_n;
        prev_rd = rd_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB);
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) send_byte(s[i], 1'b1);
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        tick(4);
        n_chk++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst_n got %b exp 0", cpu_rst_n); end
        n_chk++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got %b exp 0", load_done); end
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        rst = 1'b0;
        tick(2);
        peek(32'd16, v);
        n_chk++; if (v !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_nop got %h exp 00000013", v); end
    endtask

    task automatic test_load;
        logic [31:0] v;
        bq_t s;
        s = '{8'hA5, 8'h02, 8'h13, 8'h05, 8'h15, 8'h00, 8'h93, 8'h05, 8'h16};
        send_seq(s);
        n_chk++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL load_midway_cpu_rst_n got %b exp 0", cpu_rst_n); end
        addr = 32'd1;
        tick(2);
        chg_cyc  = -1;
        rise_cyc = -1;
        send_byte(8'h00, 1'b1);
        n_chk++; if (chg_cyc < 0 || rise_cyc != chg_cyc + 1) begin n_fail++; $display("FAIL load_release_timing rise %0d write %0d exp rise=write+1", rise_cyc, chg_cyc); end
        peek(32'd0, v);
        n_chk++; if (v !== 32'h0015_0513) begin n_fail++; $display("FAIL load_mem0 got %h exp 00150513", v); end
        peek(32'd1, v);
        n_chk++; if (v !== 32'h0016_0593) begin n_fail++; $display("FAIL load_mem1 got %h exp 00160593", v); end
        n_chk++; if (cpu_rst_n !== 1'b1 || load_done !== 1'b1) begin n_fail++; $display("FAIL load_run got rst_n %b done %b exp 1 1", cpu_rst_n, load_done); end
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL load_frame_err got %b exp 0", frame_err); end
    endtask

    task automatic test_reload;
        logic [31:0] v;
        int t0;
        bq_t s;
        send_byte(8'h3C, 1'b1);
        n_chk++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL reload_ignore got %b exp 1", cpu_rst_n); end
        fall_cyc = -1;
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        n_chk++; if (fall_cyc - t0 <= 72 || fall_cyc - t0 > 88) begin n_fail++; $display("FAIL reload_fall_timing got %0d exp in (72,88]", fall_cyc - t0); end
        n_chk++; if (cpu_rst_n !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL reload_hold got rst_n %b done %b exp 0 0", cpu_rst_n, load_done); end
        s = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_seq(s);
        peek(32'd0, v);
        n_chk++; if (v !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL reload_mem0 got %h exp ddccbbaa", v); end
        peek(32'd1, v);
        n_chk++; if (v !== 32'h0016_0593) begin n_fail++; $display("FAIL reload_mem1 got %h exp 00160593", v); end
        n_chk++; if (cpu_rst_n !== 1'b1 || load_done !== 1'b1) begin n_fail++; $display("FAIL reload_run got rst_n %b done %b exp 1 1", cpu_rst_n, load_done); end
    endtask

    task automatic test_oob_read;
        logic [31:0] v;
        peek(32'd16, v);
        n_chk++; if (v !== 32'h0000_0013) begin n_fail++; $display("FAIL oob_16 got %h exp 00000013", v); end
        peek(32'hFFFF_FFFF, v);
        n_chk++; if (v !== 32'h0000_0013) begin n_fail++; $display("FAIL oob_ffffffff got %h exp 00000013", v); end
        peek(32'd15, v);
        n_chk++; if (v === 32'h0000_0013) begin n_fail++; $display("FAIL oob_15 got %h exp not NOP-substituted", v); end
    endtask

    task automatic test_len_errors;
        logic [31:0] v;
        bq_t s;
        s = '{8'hA5, 8'h00};
        send_seq(s);
        n_chk++; if (frame_err !== 1'b1 || cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL len0 got ferr %b rst_n %b exp 1 0", frame_err, cpu_rst_n); end
        s = '{8'hA5, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04};
        send_seq(s);
        peek(32'd0, v);
        n_chk++; if (v !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL len17_nowrite got %h exp ddccbbaa", v); end
        n_chk++; if (frame_err !== 1'b1 || cpu_rst_n !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL len17 got ferr %b rst_n %b done %b exp 1 0 0", frame_err, cpu_rst_n, load_done); end
        s = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(s);
        peek(32'd0, v);
        n_chk++; if (v !== 32'h4433_2211) begin n_fail++; $display("FAIL err_recover_mem0 got %h exp 44332211", v); end
        n_chk++; if (cpu_rst_n !== 1'b1 || frame_err !== 1'b1) begin n_fail++; $display("FAIL err_recover got rst_n %b ferr %b exp 1 1", cpu_rst_n, frame_err); end
    endtask

    task automatic test_full_depth;
        logic [31:0] v;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int w = 0; w < DEPTH; w++) begin
            send_byte(8'(w), 1'b1);
            send_byte(8'h5A, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
        end
        peek(32'd0, v);
        n_chk++; if (v !== 32'h0000_5A00) begin n_fail++; $display("FAIL depth_mem0 got %h exp 00005a00", v); end
        peek(32'd15, v);
        n_chk++; if (v !== 32'h0000_5A0F) begin n_fail++; $display("FAIL depth_mem15 got %h exp 00005a0f", v); end
        n_chk++; if (cpu_rst_n !== 1'b1 || load_done !== 1'b1) begin n_fail++; $display("FAIL depth_run got rst_n %b done %b exp 1 1", cpu_rst_n, load_done); end
    endtask

    task automatic test_stop_bit_error;
        logic [31:0] v;
        bq_t s;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_cleared got %b exp 0", frame_err); end
        peek(32'd0, v);
        n_chk++; if (v !== 32'h0000_5A00) begin n_fail++; $display("FAIL mem_kept_over_rst got %h exp 00005a00", v); end
        s = '{8'hA5, 8'h01, 8'h11};
        send_seq(s);
        send_byte(8'h22, 1'b0);
        n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL stop_err_flag got %b exp 1", frame_err); end
        s = '{8'h33, 8'h44, 8'h55, 8'h66};
        send_seq(s);
        peek(32'd0, v);
        n_chk++; if (v !== 32'h5544_3311) begin n_fail++; $display("FAIL stop_err_mem0 got %h exp 55443311", v); end
        n_chk++; if (cpu_rst_n !== 1'b1 || load_done !== 1'b1) begin n_fail++; $display("FAIL stop_err_run got rst_n %b done %b exp 1 1", cpu_rst_n, load_done); end
    endtask

    task automatic test_reset_mid_load;
        logic [31:0] v;
        bq_t s;
        s = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_seq(s);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        n_chk++; if (cpu_rst_n !== 1'b0 || load_done !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got rst_n %b done %b ferr %b exp 0 0 0", cpu_rst_n, load_done, frame_err); end
        s = '{8'h07, 8'h08};
        send_seq(s);
        peek(32'd0, v);
        n_chk++; if (v !== 32'h0403_0201) begin n_fail++; $display("FAIL midrst_mem0 got %h exp 04030201", v); end
        peek(32'd1, v);
        n_chk++; if (v !== 32'h0000_5A01) begin n_fail++; $display("FAIL midrst_mem1 got %h exp 00005a01", v); end
        n_chk++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b exp 0", cpu_rst_n); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_reload();
        test_oob_read();
        test_len_errors();
        test_full_depth();
        test_stop_bit_error();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
